// File: rtl/psram_resp_pkg.sv
// Shared definitions for the HyperRAM device-side responder: FSM states,
// command/address field positions, CR0 reset value, latency decode and the
// latency-collision LFSR polynomial.
package psram_resp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CA,
      ST_REG_WR,
      ST_LATENCY,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_DONE
   } state_e;

   // Command/address field positions within CA[47:0]
   localparam int CA_RW     = 47;   // 1 = read
   localparam int CA_AS     = 46;   // 1 = register space
   localparam int CA_ROW_HI = 33;
   localparam int CA_ROW_LO = 16;
   localparam int CA_COL_HI = 2;
   localparam int CA_CR_SEL = 24;   // must be 1 to address CR0
   localparam int CA_CR_LSB = 0;    // must be 0 to address CR0

   localparam logic [15:0] CR0_RST   = 16'h8F1F;
   // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   // Initial latency in clocks from CR0[7:4]; unlisted codes fall back to 6
   function automatic logic [3:0] lat_decode(input logic [3:0] code);
      case (code)
         4'hE:    lat_decode = 4'd3;
         4'hF:    lat_decode = 4'd4;
         4'h0:    lat_decode = 4'd5;
         default: lat_decode = 4'd6;
      endcase
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? LFSR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Backing store of the responder: 2^ADDR_W x 16 synchronous RAM with a
// per-byte write enable and one registered read port gated by re.
module psram_resp_mem #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [1:0]        be,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);

   logic [15:0] mem [2**ADDR_W];

   // byte-masked write and registered read; rdata holds while re is low
   always_ff @(posedge clk) begin
      if (we) begin
         if (be[1]) mem[waddr][15:8] <= wdata[15:8];
         if (be[0]) mem[waddr][7:0]  <= wdata[7:0];
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/psram_responder.sv
// HyperRAM device-side responder on the controller's DDR-split bus.
// The controller is expected to drop cs_n at least one clock before the
// first CK pulse so RWDS can already be driven during CA cycle n=0.
// Optional build macro PSRAM_RESPONDER_RANDOM_LAT_EN: per-transaction LFSR
// that forces 2x latency on 1 in 8 transactions when CR0[3]=0.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | cs_n high, buses tristated
// ST_CA      | shifting in CA[47:0] on n=0..2, RWDS shows the 2x flag
// ST_REG_WR  | zero-latency CR0 write, data at n=3
// ST_LATENCY | waiting for the first data cycle (read preamble driven)
// ST_WR_DATA | linear write burst into the RAM
// ST_RD_DATA | linear read burst (RAM or CR0)
// ST_DONE    | transaction finished, waiting for cs_n high
module psram_responder
   import psram_resp_pkg::*;
#(
   parameter int          ADDR_W    = 10,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cs_n,
   input  logic        ck_e,
   input  logic [7:0]  dq_in_ris,
   input  logic [7:0]  dq_in_fal,
   input  logic        rwds_in_ris,
   input  logic        rwds_in_fal,
   output logic [7:0]  dq_out_ris,
   output logic [7:0]  dq_out_fal,
   output logic        dq_oen,
   output logic        rwds_out_ris,
   output logic        rwds_out_fal,
   output logic        rwds_oen,
   output logic [15:0] cr0
);

   state_e            state, state_nx;
   logic [4:0]        cnt;
   logic [31:0]       ca;
   logic              rd, regsp, cr_sel, dbl, dbl_nx;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       rdata, rd_word;
   logic [47:0]       ca_full;
   logic [20:0]       word_full;
   logic [4:0]        lat5, dstart;
   logic              fire, mem_we, fetch;
   logic [7:0]        dq_ris_nx, dq_fal_nx;
   logic              dq_oen_nx, rwds_ris_nx, rwds_fal_nx, rwds_oen_nx;
   logic              unused_bits;

   assign fire      = ck_e & ~cs_n;
   assign ca_full   = {ca, dq_in_ris, dq_in_fal};
   assign word_full = {ca_full[CA_ROW_HI:CA_ROW_LO], ca_full[CA_COL_HI:0]};
   assign lat5      = {1'b0, lat_decode(cr0[7:4])};
   assign dstart    = 5'd2 + (dbl ? (lat5 << 1) : lat5);
   assign rd_word   = regsp ? cr0 : rdata;
   assign mem_we    = fire && (state == ST_WR_DATA);
   // one word ahead of the outgoing data so the RAM output is ready in time
   assign fetch     = fire && rd && !regsp && (cnt >= dstart - 5'd2) &&
                      ((state == ST_LATENCY) || (state == ST_RD_DATA));

`ifdef PSRAM_RESPONDER_RANDOM_LAT_EN
   logic [15:0] lfsr;

   // one LFSR step per transaction, on entry into CA
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                         lfsr <= LFSR_SEED;
      else if (state == ST_IDLE && !cs_n)  lfsr <= lfsr_next(lfsr);
   end

   assign dbl_nx      = cr0[3] | (lfsr[2:0] == 3'b000);
   assign unused_bits = ^{ca_full, word_full};
`else
   assign dbl_nx      = cr0[3];
   assign unused_bits = ^{ca_full, word_full, LFSR_SEED};
`endif

   psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .be    ({~rwds_in_ris, ~rwds_in_fal}),
      .waddr (addr),
      .wdata ({dq_in_ris, dq_in_fal}),
      .re    (fetch),
      .raddr (addr),
      .rdata (rdata)
   );

   // state and registered bus outputs
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state        <= ST_IDLE;
         dq_out_ris   <= 8'h00;
         dq_out_fal   <= 8'h00;
         dq_oen       <= 1'b1;
         rwds_out_ris <= 1'b0;
         rwds_out_fal <= 1'b0;
         rwds_oen     <= 1'b1;
      end else begin
         state        <= state_nx;
         dq_out_ris   <= dq_ris_nx;
         dq_out_fal   <= dq_fal_nx;
         dq_oen       <= dq_oen_nx;
         rwds_out_ris <= rwds_ris_nx;
         rwds_out_fal <= rwds_fal_nx;
         rwds_oen     <= rwds_oen_nx;
      end
   end

   // next state and next bus values; everything holds while ck_e is low
   always_comb begin
      state_nx    = state;
      dq_ris_nx   = dq_out_ris;
      dq_fal_nx   = dq_out_fal;
      dq_oen_nx   = dq_oen;
      rwds_ris_nx = rwds_out_ris;
      rwds_fal_nx = rwds_out_fal;
      rwds_oen_nx = rwds_oen;
      if (cs_n) begin
         state_nx    = ST_IDLE;
         dq_ris_nx   = 8'h00;
         dq_fal_nx   = 8'h00;
         dq_oen_nx   = 1'b1;
         rwds_ris_nx = 1'b0;
         rwds_fal_nx = 1'b0;
         rwds_oen_nx = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx    = ST_CA;
               rwds_oen_nx = 1'b0;
               rwds_ris_nx = dbl_nx;
               rwds_fal_nx = dbl_nx;
            end
            ST_CA: begin
               if (ck_e && cnt == 5'd2) begin
                  rwds_ris_nx = 1'b0;
                  rwds_fal_nx = 1'b0;
                  if (!ca_full[CA_RW] && ca_full[CA_AS]) begin
                     state_nx    = ST_REG_WR;
                     rwds_oen_nx = 1'b1;
                  end else begin
                     state_nx    = ST_LATENCY;
                     rwds_oen_nx = ~ca_full[CA_RW];
                  end
               end
            end
            ST_REG_WR: if (ck_e) state_nx = ST_DONE;
            ST_LATENCY: begin
               if (ck_e && cnt == dstart - 5'd1) begin
                  if (rd) begin
                     state_nx                 = ST_RD_DATA;
                     dq_oen_nx                = 1'b0;
                     rwds_ris_nx              = 1'b1;
                     rwds_fal_nx              = 1'b0;
                     {dq_ris_nx, dq_fal_nx}   = rd_word;
                  end else begin
                     state_nx = ST_WR_DATA;
                  end
               end
            end
            ST_RD_DATA: if (ck_e) {dq_ris_nx, dq_fal_nx} = rd_word;
            ST_WR_DATA, ST_DONE: ;
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // cycle index, CA capture, burst address and CR0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt    <= 5'd0;
         ca     <= 32'h0;
         rd     <= 1'b0;
         regsp  <= 1'b0;
         cr_sel <= 1'b0;
         dbl    <= 1'b0;
         addr   <= '0;
         cr0    <= CR0_RST;
      end else if (state == ST_IDLE) begin
         cnt <= 5'd0;
         if (!cs_n) dbl <= dbl_nx;
      end else if (fire) begin
         if (cnt != 5'h1F) cnt <= cnt + 5'd1;
         if (state == ST_CA) begin
            ca <= {ca[15:0], dq_in_ris, dq_in_fal};
            if (cnt == 5'd2) begin
               rd     <= ca_full[CA_RW];
               regsp  <= ca_full[CA_AS];
               cr_sel <= ca_full[CA_CR_SEL] & ~ca_full[CA_CR_LSB];
               addr   <= word_full[ADDR_W-1:0];
            end
         end
         if (state == ST_REG_WR && cr_sel) cr0 <= {dq_in_ris, dq_in_fal};
         if (mem_we || fetch) addr <= addr + 1'b1;
      end
   end

endmodule

// File: doc/psram_responder.md
# psram_responder

Synthesizable HyperRAM target (device side) that answers the PsramController's command/address, latency and data phases, backed by a small byte-maskable RAM. It sits on the controller's DDR-split bus: per-cycle rising/falling byte pairs, in place of the IDDR/ODDR pads. Its uses are self-test and simulation of the memory path without the on-chip die.

## Interface
- ADDR_W, 10: word-address bits kept; the upper CA address bits are ignored and the RAM holds 2^ADDR_W 16-bit words.
- LFSR_SEED, 16'hACE1: seed of the latency-collision LFSR, used only under the macro.
- clk  in  1  clock; one clock; all logic on its rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- cs_n  in  1  chip select from the controller; high aborts any operation.
- ck_e  in  1  one CK pulse occurs this cycle; cycles with ck_e low are not counted.
- dq_in_ris, dq_in_fal  in  8 each  DQ byte sampled at the rising / falling CK edge.
- rwds_in_ris, rwds_in_fal  in  1 each  RWDS sampled at the two edges; used as the write mask.
- dq_out_ris, dq_out_fal  out  8 each  read-data bytes; ris carries bits 15:8.
- dq_oen  out  1  1 = DQ tristated.
- rwds_out_ris, rwds_out_fal  out  1 each  latency flag or read strobe.
- rwds_oen  out  1  1 = RWDS tristated.
- cr0  out  16  current configuration register 0.

## Operation
- **Cycle index.** n = count of ck_e-high cycles since the falling edge of cs_n, starting at 0.
- **CA capture.** CA[47:0] is shifted in from {ris,fal} on n=0,1,2, MSB first.
- **CA fields.**
  - CA[47] = 1 read, 0 write.
  - CA[46] = 1 register space, 0 memory space.
  - Word address = {CA[33:16], CA[2:0]}, truncated to ADDR_W bits.
- **Latency setting.** L is decoded from CR0[7:4]:
  - 1110 → 3, 1111 → 4, 0000 → 5, 0001 → 6.
  - Any other code → 6.
- **Latency multiplier.** CR0[3]=1 selects fixed 2x latency. CR0[3]=0 selects 1x, unless a collision is flagged (see Configuration).
- **RWDS during CA.** Driven on n=0..2 (rwds_oen=0), both halves = the 2x flag.
- **Register write** (CA[47]=0, CA[46]=1): zero latency. Data is the byte pair at n=3.
  - It loads CR0 only if CA[24]=1 and CA[0]=0; otherwise it is ignored.
  - Then go to DONE.
- **Memory write.** Data starts at n = 2+L (1x) or 2+2L (2x), one word per cycle (linear burst).
  - RWDS carries the byte mask: rwds_in_ris=1 masks bits 15:8, rwds_in_fal=1 masks bits 7:0.
  - The address increments and wraps modulo 2^ADDR_W.
- **Read** (memory or register space).
  - From n=3 until data: RWDS preamble 0/0 is driven.
  - From n = 2+L (or 2+2L): drive one word per cycle with rwds_out_ris=1, rwds_out_fal=0, dq_oen=0.
  - Memory reads use the incrementing, wrapping address.
  - Register reads return CR0 for every word.
- **States.** IDLE → CA → {REG_WR, LATENCY} → {WR_DATA, RD_DATA} → DONE.
  - DONE holds outputs tristated until cs_n goes high.
  - cs_n high in any state → IDLE on the next clock. Words already written are kept; the burst is dropped.
- **Reset values.**
  - dq_oen=1, rwds_oen=1.
  - dq_out_*=0, rwds_out_*=0.
  - cr0=16'h8F1F (L=6, fixed 2x); state IDLE.

## Timing
- All outputs are registered. The values shown during cycle n are computed at the end of cycle n-1.
- The RAM address is prefetched one cycle ahead so that data is present at the first data cycle.
- When ck_e is low with cs_n low, all state freezes.
- At the turnaround, dq_oen stays 1 until the first read word. After the last word it returns to 1 one cycle after cs_n rises.
- Simultaneous cs_n rise and data word: the word is discarded.

## Configuration
- **PSRAM_RESPONDER_RANDOM_LAT_EN defined:** a 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1, seeded LFSR_SEED at reset) steps once per transaction. With CR0[3]=0, the transaction runs at 2x latency when its 3 LSBs are 000 (1 in 8).
- **Undefined:** CR0[3]=0 always gives 1x; no LFSR is instantiated.

## Structure
- **Package `psram_resp_pkg`:**
  - state enum;
  - CA field bit positions;
  - CR0 reset value;
  - latency decode function `lat_decode(cr0[7:4])`;
  - LFSR polynomial.
- **One sub-module, `psram_resp_mem`:** 2^ADDR_W x 16 synchronous RAM with a two-bit byte-enable write port and one read port.

## Test plan
- After reset: cr0=16'h8F1F, dq_oen=1, rwds_oen=1; in CA, the RWDS halves = 1/1 (fixed 2x).
- CA 0x600001000000 then data 0x8FEF at n=3: cr0=16'h8FEF (L=3, 2x fixed). The same CA with CA[24]=0 leaves cr0 unchanged.
- With cr0=16'h8FE7 (L=3, variable, macro off): write 0x1234 to word 5 with data at n=5, then read word 5. Read sees RWDS 0/0 at n=3..4, then 0x1234 with rwds_out_ris=1 at n=5.
- Byte write 0xABCD to word 5 with rwds_in_ris=0, rwds_in_fal=1: readback 0xAB34.
- Burst write of 3 words to the top address (2^ADDR_W-1): words land at addresses -1, 0, 1 (wrap). cs_n raised mid-burst after the 2nd word: the 3rd is not written and the next transaction starts cleanly.
- Macro on, cr0=16'h8FE7, 64 transactions from LFSR_SEED: every transaction whose LFSR LSBs are 000 flags RWDS=1 in CA and places data at n=8; all others place data at n=5.
